mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: last-served-pointer tie break and direct owner handoff.
// Define ARB_HOLD_LIMIT_EN to force a handoff after MAX_HOLD contended owner cycles.
module mem_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rd0,
  input  logic        rd1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   lsp_q, lsp_d;

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;
  logic       hold_expired;
  logic       rival_waiting;

  assign hold_expired  = (hold_q == 8'(MAX_HOLD - 1));
  assign rival_waiting = ((state_q == StOwn0) && req1) || ((state_q == StOwn1) && req0);

  // Cleared on any grant change; saturates instead of wrapping.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = 8'd0;
    end else if (rival_waiting && (hold_q != 8'hff)) begin
      hold_d = hold_q + 8'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    lsp_d   = lsp_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = lsp_q ? StOwn0 : StOwn1;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          lsp_d   = 1'b0;
          state_d = req1 ? StOwn1 : StIdle;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_expired && req1) begin
          lsp_d   = 1'b0;
          state_d = StOwn1;
        end
`endif
      end
      StOwn1: begin
        if (!req1) begin
          lsp_d   = 1'b1;
          state_d = req0 ? StOwn0 : StIdle;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_expired && req0) begin
          lsp_d   = 1'b1;
          state_d = StOwn0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lsp_q   <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      lsp_q   <= lsp_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt0  = (state_q == StOwn0);
  assign gnt1  = (state_q == StOwn1);
  assign rdata = mem_rdata;

  // Simultaneous rd and wr is illegal: nothing is issued but the grant stays.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state_q)
      StOwn0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_read  = req0 & rd0 & ~wr0;
        mem_write = req0 & wr0 & ~rd0;
        ack0      = mem_read | mem_write;
      end
      StOwn1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_read  = req1 & rd1 & ~wr1;
        mem_write = req1 & wr1 & ~rd1;
        ack1      = mem_read | mem_write;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle comparison against a behavioural ownership model,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int MaxHold = 8;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HoldLimit = 1'b1;
`else
  localparam bit HoldLimit = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, rd0, rd1, wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read, mem_write;
  logic [7:0]  mem_rdata;

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  // Model: who owns the bus, who was served last, how long the rival has waited.
  int m_owner = -1;
  int m_lsp   = 1;
  int m_wait  = 0;

  mem_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .rd0       (rd0),
    .rd1       (rd1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    bit mine, theirs;
    if (reset) begin
      m_owner = -1;
      m_lsp   = 1;
      m_wait  = 0;
    end else if (m_owner < 0) begin
      if (req0 && req1) m_owner = (m_lsp == 1) ? 0 : 1;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
      m_wait = 0;
    end else begin
      mine   = (m_owner == 0) ? req0 : req1;
      theirs = (m_owner == 0) ? req1 : req0;
      if (!mine || (HoldLimit && theirs && (m_wait + 1 >= MaxHold))) begin
        m_lsp   = m_owner;
        m_owner = theirs ? 1 - m_owner : -1;
        m_wait  = 0;
      end else if (theirs && m_wait < 255) begin
        m_wait = m_wait + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_rd, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    if (check_en) begin
      e_rd = 0; e_wr = 0; e_addr = 0; e_wd = 0;
      if (m_owner == 0) begin
        e_addr = addr0; e_wd = wdata0;
        e_rd = req0 && rd0 && !wr0;
        e_wr = req0 && wr0 && !rd0;
      end else if (m_owner == 1) begin
        e_addr = addr1; e_wd = wdata1;
        e_rd = req1 && rd1 && !wr1;
        e_wr = req1 && wr1 && !rd1;
      end
      chk("gnt0", 32'(gnt0), 32'(m_owner == 0));
      chk("gnt1", 32'(gnt1), 32'(m_owner == 1));
      chk("mem_read", 32'(mem_read), 32'(e_rd));
      chk("mem_write", 32'(mem_write), 32'(e_wr));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("ack0", 32'(ack0), 32'((m_owner == 0) && (e_rd || e_wr)));
      chk("ack1", 32'(ack1), 32'((m_owner == 1) && (e_rd || e_wr)));
      chk("rdata", 32'(rdata), 32'(mem_rdata));
    end
  end

  initial begin
    reset = 1; req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 8'h00;
    cyc(1);
    check_en = 1'b1;
    cyc(1);
    #2;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    reset = 0;

    // Single read by requester 0: one-cycle grant latency.
    cyc(1);
    req0 = 1; rd0 = 1; addr0 = 16'h0010; mem_rdata = 8'hA5;
    #2 chk("rd_gnt0_before_edge", 32'(gnt0), 0);
    cyc(1);
    #2;
    chk("rd_gnt0", 32'(gnt0), 1);
    chk("rd_mem_read", 32'(mem_read), 1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0010);
    chk("rd_ack0", 32'(ack0), 1);
    chk("rd_rdata", 32'(rdata), 32'hA5);
    cyc(1);
    rd0 = 0; wr0 = 1; addr0 = 16'h0020; wdata0 = 8'h3C;
    #2 chk("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
    cyc(1);
    req0 = 0; wr0 = 0;
    cyc(1);
    reset = 1;
    cyc(1);
    reset = 0;

    // Tie after reset goes to 0, then direct handoff to 1, then tie goes to 0 again.
    req0 = 1; req1 = 1; rd1 = 1; addr1 = 16'h0055; mem_rdata = 8'h11;
    cyc(1);
    #2;
    chk("tie_gnt0", 32'(gnt0), 1);
    chk("tie_gnt1", 32'(gnt1), 0);
    cyc(2);
    req0 = 0;
    cyc(1);
    #2;
    chk("handoff_gnt1", 32'(gnt1), 1);
    chk("handoff_gnt0", 32'(gnt0), 0);
    chk("handoff_addr", 32'(mem_addr), 32'h0055);
    chk("handoff_ack1", 32'(ack1), 1);
    req1 = 0; rd1 = 0;
    cyc(1);
    req0 = 1; req1 = 1;
    cyc(1);
    #2 chk("tie2_gnt0", 32'(gnt0), 1);
    req0 = 0; req1 = 0;
    cyc(1);
    req0 = 1; req1 = 1;
    cyc(1);
    #2 chk("tie3_gnt1", 32'(gnt1), 1);
    req0 = 0; req1 = 0;
    reset = 1;
    cyc(1);
    reset = 0;

    // Contended hold: owner 0 writing continuously while 1 waits.
    req0 = 1; wr0 = 1; addr0 = 16'h0300; wdata0 = 8'h77; req1 = 1;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      #2 chk("hold_gnt0", 32'(gnt0), 1);
      chk("hold_ack0", 32'(ack0), 1);
      cyc(1);
    end
    #2;
`ifdef ARB_HOLD_LIMIT_EN
    chk("hold_limit_gnt1", 32'(gnt1), 1);
    chk("hold_limit_gnt0", 32'(gnt0), 0);
`else
    chk("hold_keep_gnt0", 32'(gnt0), 1);
    cyc(20);
    #2 chk("hold_keep_long_gnt0", 32'(gnt0), 1);
`endif
    req0 = 0; wr0 = 0; req1 = 0;
    reset = 1;
    cyc(1);
    reset = 0;

    // Illegal rd+wr while owning: no access, grant kept.
    req1 = 1; rd1 = 1; wr1 = 1; addr1 = 16'h0077;
    cyc(1);
    #2;
    chk("ill_gnt1", 32'(gnt1), 1);
    chk("ill_mem_read", 32'(mem_read), 0);
    chk("ill_mem_write", 32'(mem_write), 0);
    chk("ill_ack1", 32'(ack1), 0);
    cyc(3);
    #2 chk("ill_gnt1_kept", 32'(gnt1), 1);

    // Reset mid-write drops everything at the next edge.
    rd1 = 0; addr1 = 16'h1234; wdata1 = 8'h5A;
    #2 chk("pre_rst_write", 32'(mem_write), 1);
    reset = 1;
    cyc(1);
    req1 = 0; wr1 = 0; reset = 0;
    #2;
    chk("midrst_gnt1", 32'(gnt1), 0);
    chk("midrst_mem_write", 32'(mem_write), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 0);
    cyc(1);

    // One-cycle pulse on req1 while 0 owns: withdrawn, never granted.
    req0 = 1; rd0 = 1; addr0 = 16'h0400;
    cyc(1);
    req1 = 1;
    cyc(1);
    req1 = 0;
    for (int i = 0; i < 5; i++) begin
      #2 chk("pulse_gnt1", 32'(gnt1), 0);
      chk("pulse_gnt0", 32'(gnt0), 1);
      cyc(1);
    end
    req0 = 0; rd0 = 0;
    cyc(3);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
